// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache address split, frame layout and FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 32 - 2 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block instruction cache with a single-request refill FSM,
// bulk invalidate and redirect-safe refills.
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int SETS  = ICACHE_SETS,
    parameter int TAG_W = 32 - 2 - $clog2(SETS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          imemREN,
    input  word_t         imemaddr,
    output logic          ihit,
    output word_t         imemload,
    input  logic          iinval,
    output logic          iREN,
    output word_t         iaddr,
    input  logic          iwait,
    input  word_t         iload,
    output icache_state_t dbg_state
);
    localparam int IDX_W = $clog2(SETS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    logic [0:0]       state;
    logic             poison;
    word_t            miss_addr;
    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    word_t            data_q [SETS];

    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] req_tag;
    logic [TAG_W-1:0] miss_tag;
    logic             lookup_hit;
    logic             idle_hit;
    logic             fill_done;
    logic             fwd_hit;
    logic             unused_addr_bits;

    assign req_idx  = imemaddr[2+IDX_W-1:2];
    assign req_tag  = imemaddr[31:2+IDX_W];
    assign miss_idx = miss_addr[2+IDX_W-1:2];
    assign miss_tag = miss_addr[31:2+IDX_W];
    assign unused_addr_bits = ^imemaddr[1:0];

    // Raw tag match; an invalidate in the same cycle suppresses the hit but does not start a refill.
    assign lookup_hit = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign idle_hit   = (state == ST_IDLE) & lookup_hit & ~iinval;
    assign fill_done  = (state == ST_FETCH) & ~iwait;
    assign fwd_hit    = fill_done & imemREN & (imemaddr[31:2] == miss_addr[31:2])
                        & ~poison & ~iinval;

    assign ihit = idle_hit | fwd_hit;

    always_comb begin
        imemload = '0;
        if (idle_hit) begin
            imemload = data_q[req_idx];
        end else if (fwd_hit) begin
            imemload = iload;
        end
    end

    // Memory handshake: iREN/iaddr are held for the whole refill; the beat completes in the
    // first cycle where iREN is high and iwait is low, and iload is consumed in that cycle.
    assign iREN      = (state == ST_FETCH);
    assign iaddr     = iREN ? miss_addr : '0;
    assign dbg_state = icache_state_t'(state);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            poison    <= 1'b0;
            miss_addr <= '0;
            valid_q   <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (imemREN & ~lookup_hit) begin
                        miss_addr <= {imemaddr[31:2], 2'b00};
                        poison    <= 1'b0;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (iinval) begin
                        poison <= 1'b1;
                    end
                    if (~iwait) begin
                        data_q[miss_idx]  <= iload;
                        tag_q[miss_idx]   <= miss_tag;
                        valid_q[miss_idx] <= ~poison & ~iinval;
                        state             <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Placed after the fill so that invalidate wins a same-cycle collision.
            if (iinval) begin
                valid_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus randomized fetch traffic
// checked against a set/tag reference model and an expected-hit queue.
module tb_icache_direct;
    import cpu_types_pkg::*;

    localparam int SETS = ICACHE_SETS;

    logic          CLK      = 1'b0;
    logic          RST      = 1'b1;
    logic          imemREN  = 1'b0;
    word_t         imemaddr = '0;
    logic          ihit;
    word_t         imemload;
    logic          iinval   = 1'b0;
    logic          iREN;
    word_t         iaddr;
    logic          iwait    = 1'b1;
    word_t         iload    = '0;
    icache_state_t dbg_state;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [63:0]   exp_q[$];
    logic [63:0]   mon_e;
    word_t         exp_iaddr = '0;
    bit            mon_en = 1'b0;

    word_t         mem[word_t];
    int            mem_wait = 0;
    int            mem_left = 0;
    bit            mem_busy = 1'b0;

    bit            ref_v[SETS];
    logic [29:0]   ref_w[SETS];

    icache_direct #(.SETS(SETS)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iinval(iinval), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic word_t mem_rd(word_t a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic int ref_idx(word_t a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic bit ref_hit(word_t a);
        int i = ref_idx(a);
        return ref_v[i] && (ref_w[i] == a[31:2]);
    endfunction

    function automatic void ref_fill(word_t a);
        int i = ref_idx(a);
        ref_v[i] = 1'b1;
        ref_w[i] = a[31:2];
    endfunction

    function automatic void ref_inval_all();
        for (int i = 0; i < SETS; i++) ref_v[i] = 1'b0;
    endfunction

    // ---------------- memory responder ----------------
    always @(posedge CLK) begin
        #1;
        if (iREN) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_left = mem_wait;
            end
            if (mem_left > 0) begin
                iwait = 1'b1;
                iload = $urandom;
                mem_left--;
            end else begin
                iwait    = 1'b0;
                iload    = mem_rd(iaddr);
                mem_busy = 1'b0;
            end
        end else begin
            iwait    = 1'b1;
            iload    = $urandom;
            mem_busy = 1'b0;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (mon_en) begin
            if (ihit) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_hit: got ihit=1 addr %h load %h, required ihit=0",
                             imemaddr, imemload);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("hit_addr", {imemaddr[31:2], 2'b00}, mon_e[63:32]);
                    chk("hit_data", imemload, mon_e[31:0]);
                end
            end else begin
                chk("load_zero_no_hit", imemload, 32'h0);
            end
            chk("iaddr", iaddr, iREN ? exp_iaddr : 32'h0);
        end
    end

    // ---------------- driver tasks (enter and leave just after a rising edge) ----------------
    task automatic fetch(input word_t a, input int w);
        word_t wa = {a[31:2], 2'b00};
        bit    hit = ref_hit(a);
        int    exp_lat = hit ? 0 : 1 + w;
        int    c = 0;
        exp_q.push_back({wa, mem_rd(wa)});
        mem_wait  = w;
        exp_iaddr = wa;
        imemREN   = 1'b1;
        imemaddr  = a;
        forever begin
            @(negedge CLK); #1;
            chk("fetch_iren", 32'(iREN), (c > 0) ? 32'd1 : 32'd0);
            if (ihit) break;
            if (c >= exp_lat + 4) begin
                n_cmp++;
                n_bad++;
                $display("FAIL fetch_timeout: got no ihit for %h after %0d cycles, required %0d",
                         a, c, exp_lat);
                break;
            end
            c++;
            @(posedge CLK); #1;
        end
        chk("fetch_latency", 32'(c), 32'(exp_lat));
        imemREN = 1'b0;
        if (!hit) ref_fill(a);
        @(posedge CLK); #1;
    endtask

    // Miss on a, then redirect imemaddr to b; optionally pulse iinval in FETCH cycle k (k>0).
    task automatic miss_then(input word_t a, input word_t b, input int w, input int k);
        word_t wa = {a[31:2], 2'b00};
        void'(mem_rd(wa));
        mem_wait  = w;
        exp_iaddr = wa;
        imemREN   = 1'b1;
        imemaddr  = a;
        for (int c = 0; c <= w + 1; c++) begin
            if (c == 1) imemaddr = b;
            iinval = (k > 0) && (c == k);
            @(negedge CLK); #1;
            chk("miss_no_hit", 32'(ihit), 32'h0);
            chk("miss_iren", 32'(iREN), (c > 0) ? 32'd1 : 32'd0);
            @(posedge CLK); #1;
        end
        iinval  = 1'b0;
        imemREN = 1'b0;
        if (k > 0) ref_inval_all();
        else       ref_fill(a);
    endtask

    task automatic inval_pulse(input word_t a);
        imemREN  = ref_hit(a);
        imemaddr = a;
        iinval   = 1'b1;
        @(negedge CLK); #1;
        chk("inval_no_hit", 32'(ihit), 32'h0);
        chk("inval_iren", 32'(iREN), 32'h0);
        ref_inval_all();
        @(posedge CLK); #1;
        iinval  = 1'b0;
        imemREN = 1'b0;
    endtask

    task automatic reset_mid(input word_t a, input int w);
        mem_wait  = w;
        exp_iaddr = {a[31:2], 2'b00};
        void'(mem_rd(exp_iaddr));
        imemREN   = 1'b1;
        imemaddr  = a;
        @(negedge CLK); #1;
        chk("rstfill_iren_c0", 32'(iREN), 32'h0);
        @(posedge CLK); #1;
        RST     = 1'b1;
        imemREN = 1'b0;
        @(negedge CLK); #1;
        chk("rstfill_iren_held", 32'(iREN), 32'h1);
        @(posedge CLK); #1;
        RST = 1'b0;
        ref_inval_all();
        @(negedge CLK); #1;
        chk("rstfill_iren", 32'(iREN), 32'h0);
        chk("rstfill_ihit", 32'(ihit), 32'h0);
        chk("rstfill_iaddr", iaddr, 32'h0);
        chk("rstfill_state", 32'(dbg_state), 32'(IDLE));
        @(posedge CLK); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        word_t a;
        word_t b;
        word_t tg;
        int    r;
        int    w;
        int    k;

        ref_inval_all();
        repeat (3) @(posedge CLK);
        #1;
        RST    = 1'b0;
        mon_en = 1'b1;
        @(negedge CLK); #1;
        chk("reset_ihit", 32'(ihit), 32'h0);
        chk("reset_imemload", imemload, 32'h0);
        chk("reset_iren", 32'(iREN), 32'h0);
        chk("reset_iaddr", iaddr, 32'h0);
        chk("reset_state", 32'(dbg_state), 32'(IDLE));
        @(posedge CLK); #1;

        // cold miss with two wait cycles, then an immediate hit
        mem[32'h40]  = 32'h2001_0005;
        mem[32'h440] = 32'h8C22_0004;
        fetch(32'h40, 2);
        fetch(32'h40, 0);

        // conflict eviction on the same frame
        fetch(32'h440, 1);
        fetch(32'h40, 0);

        // redirects during a refill (same frame, then different frames)
        miss_then(32'h80, 32'h100, 3, 0);
        fetch(32'h100, 0);
        fetch(32'h80, 0);
        miss_then(32'h180, 32'h104, 2, 0);
        fetch(32'h104, 0);
        fetch(32'h180, 0);

        // invalidate on a hit, and in the completion cycle of a refill
        fetch(32'h40, 0);
        fetch(32'h40, 0);
        inval_pulse(32'h40);
        fetch(32'h40, 1);
        miss_then(32'hC0, 32'hC0, 1, 2);
        fetch(32'hC0, 0);

        // invalidate early in a refill poisons the fill
        miss_then(32'h48, 32'h48, 3, 1);
        fetch(32'h48, 0);

        // reset during a refill
        fetch(32'h40, 0);
        reset_mid(32'h204, 3);
        fetch(32'h40, 0);

        // idle traffic
        for (int i = 0; i < 10; i++) begin
            imemREN  = 1'b0;
            imemaddr = $urandom;
            @(negedge CLK); #1;
            chk("idle_iren", 32'(iREN), 32'h0);
            chk("idle_ihit", 32'(ihit), 32'h0);
            @(posedge CLK); #1;
        end

        // randomized traffic over a small address pool to force hits, conflicts and redirects
        for (int i = 0; i < 200; i++) begin
            tg = word_t'($urandom_range(0, 3));
            if (tg == 3) tg = $urandom;
            a = (tg << 6) | (word_t'($urandom_range(0, 3)) << 2) | word_t'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            w = $urandom_range(0, 3);
            if (r == 0) begin
                inval_pulse(a);
            end else if (r <= 2 && !ref_hit(a)) begin
                b = $urandom;
                if (b[31:2] == a[31:2]) b = b ^ 32'h4;
                k = (r == 2) ? $urandom_range(1, w + 1) : 0;
                miss_then(a, (k > 0) ? a : b, w, k);
            end else begin
                fetch(a, w);
            end
        end

        repeat (2) @(posedge CLK);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
